// File: rtl/iir_df1_biquad_axis.sv
// Direct Form I biquad, 3-edge pipeline (capture, multiply, sum/limit), one output per accepted sample.
// Define IIR_DF1_SATURATE_EN to saturate y[n]; otherwise y[n] wraps to inout_width bits.
module iir_df1_biquad_axis #(
  parameter int coeff_width  = 16,
  parameter int inout_width  = 16,
  parameter int a1_int_coeff = -31880,
  parameter int a2_int_coeff = 15531,
  parameter int bo_int_coeff = 167,
  parameter int b1_int_coeff = -302,
  parameter int b2_int_coeff = 167
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_axis_tvalid,
  input  logic signed [inout_width-1:0] s_axis_tdata,
  output logic signed [inout_width-1:0] m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tready
);

  localparam int F  = coeff_width - 2;
  localparam int PW = inout_width + coeff_width;
  localparam int AW = PW + 3;

  // Feedback coefficients are stored negated so every tap is a plain add.
  localparam logic signed [PW-1:0] C_B0  = PW'(bo_int_coeff);
  localparam logic signed [PW-1:0] C_B1  = PW'(b1_int_coeff);
  localparam logic signed [PW-1:0] C_B2  = PW'(b2_int_coeff);
  localparam logic signed [PW-1:0] C_NA1 = PW'(-a1_int_coeff);
  localparam logic signed [PW-1:0] C_NA2 = PW'(-a2_int_coeff);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_PROD, ST_SUM} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic signed [inout_width-1:0] r_x0, r_x1, r_x2, r_y1, r_y2;
  logic signed [PW-1:0]          r_p0, r_p1, r_p2, r_p3, r_p4;
  logic signed [inout_width-1:0] r_tdata;
  logic                          r_tvalid;

  logic signed [AW-1:0]          w_acc;
  logic signed [AW-1:0]          w_shift;
  logic signed [inout_width-1:0] w_y;
  logic                          w_accept;

  assign w_accept      = (r_state == ST_IDLE) && s_axis_tvalid;
  assign m_axis_tready = (r_state == ST_IDLE);
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tdata  = r_tdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_INIT;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: w_state_nxt = ST_IDLE;
      ST_IDLE: if (s_axis_tvalid) w_state_nxt = ST_PROD;
      ST_PROD: w_state_nxt = ST_SUM;
      ST_SUM:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  assign w_acc = AW'(r_p0) + AW'(r_p1) + AW'(r_p2) + AW'(r_p3) + AW'(r_p4);
  assign w_shift = w_acc >>> F;

`ifdef IIR_DF1_SATURATE_EN
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-inout_width+1){1'b0}}, {(inout_width-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-inout_width+1){1'b1}}, {(inout_width-1){1'b0}}};

  always_comb begin
    w_y = w_shift[inout_width-1:0];
    if (w_shift > SAT_MAX)      w_y = {1'b0, {(inout_width-1){1'b1}}};
    else if (w_shift < SAT_MIN) w_y = {1'b1, {(inout_width-1){1'b0}}};
  end
`else
  logic w_unused;
  assign w_unused = ^w_shift;

  always_comb begin
    w_y = w_shift[inout_width-1:0];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x0     <= '0;
      r_x1     <= '0;
      r_x2     <= '0;
      r_y1     <= '0;
      r_y2     <= '0;
      r_p0     <= '0;
      r_p1     <= '0;
      r_p2     <= '0;
      r_p3     <= '0;
      r_p4     <= '0;
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
    end else begin
      r_tvalid <= 1'b0;
      if (w_accept) r_x0 <= s_axis_tdata;
      if (r_state == ST_PROD) begin
        r_p0 <= PW'(r_x0) * C_B0;
        r_p1 <= PW'(r_x1) * C_B1;
        r_p2 <= PW'(r_x2) * C_B2;
        r_p3 <= PW'(r_y1) * C_NA1;
        r_p4 <= PW'(r_y2) * C_NA2;
      end
      // History only advances once the result exists, so dropped samples never touch it.
      if (r_state == ST_SUM) begin
        r_tdata  <= w_y;
        r_tvalid <= 1'b1;
        r_x2     <= r_x1;
        r_x1     <= r_x0;
        r_y2     <= r_y1;
        r_y1     <= w_y;
      end
    end
  end

endmodule

// File: tb/tb_iir_df1_biquad_axis.sv
// Directed bench for iir_df1_biquad_axis: reset, impulse, step, drop, back-to-back, sine, limiting.
module tb_iir_df1_biquad_axis;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s_axis_tvalid = 1'b0;
  logic signed [15:0] s_axis_tdata = '0;
  logic signed [15:0] m_axis_tdata;
  logic m_axis_tvalid, m_axis_tready;

  logic s2_tvalid = 1'b0;
  logic signed [15:0] s2_tdata = '0;
  logic signed [15:0] m2_tdata;
  logic m2_tvalid, m2_tready;

  int n_cmp = 0;
  int n_err = 0;
  int out_cnt = 0;
  logic signed [15:0] out_q[$];
  longint mx1 = 0, mx2 = 0, my1 = 0, my2 = 0;

  always #10 clk = ~clk;

  iir_df1_biquad_axis dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready)
  );

  iir_df1_biquad_axis #(
    .coeff_width(16), .inout_width(16),
    .a1_int_coeff(0), .a2_int_coeff(0),
    .bo_int_coeff(32767), .b1_int_coeff(0), .b2_int_coeff(0)
  ) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tvalid(s2_tvalid), .s_axis_tdata(s2_tdata),
    .m_axis_tdata(m2_tdata), .m_axis_tvalid(m2_tvalid), .m_axis_tready(m2_tready)
  );

  always @(posedge clk) begin
    #1;
    if (m_axis_tvalid === 1'b1) begin
      out_q.push_back(m_axis_tdata);
      out_cnt++;
    end
  end

  initial begin
    #4ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic model_reset;
    mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
  endtask

  task automatic model_step(input longint x, output logic signed [15:0] y);
    longint acc, q;
    acc = 167 * x - 302 * mx1 + 167 * mx2 + 31880 * my1 - 15531 * my2;
    q = acc >>> 14;
`ifdef IIR_DF1_SATURATE_EN
    if (q > 32767) q = 32767;
    else if (q < -32768) q = -32768;
`endif
    y = q[15:0];
    mx2 = mx1; mx1 = x; my2 = my1; my1 = longint'(y);
  endtask

  task automatic send(input logic signed [15:0] x, output logic signed [15:0] y,
                      output int lat, output int plen);
    int n;
    @(negedge clk);
    @(negedge clk);
    n = 0;
    while (m_axis_tready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    s_axis_tdata = x;
    s_axis_tvalid = 1'b1;
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    lat = 1;
    plen = 0;
    while (m_axis_tvalid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    y = m_axis_tdata;
    if (m_axis_tvalid === 1'b1) begin
      plen = 1;
      @(posedge clk); #1;
      if (m_axis_tvalid !== 1'b0) plen = 2;
    end
  endtask

  task automatic apply_reset;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
  endtask

  task automatic test_reset;
    logic bad_v, bad_d, bad_r;
    bad_v = 1'b0; bad_d = 1'b0; bad_r = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      s_axis_tvalid = (i % 3 == 1);
      s_axis_tdata = 16'sd1234;
      if (m_axis_tvalid !== 1'b0) bad_v = 1'b1;
      if (m_axis_tdata !== 16'sd0) bad_d = 1'b1;
      if (m_axis_tready !== 1'b0) bad_r = 1'b1;
    end
    s_axis_tvalid = 1'b0;
    n_cmp++; if (bad_v !== 1'b0) begin n_err++; $display("FAIL rst_tvalid: saw pulse=%b, required 0", bad_v); end
    n_cmp++; if (bad_d !== 1'b0) begin n_err++; $display("FAIL rst_tdata: nonzero seen=%b, required 0", bad_d); end
    n_cmp++; if (bad_r !== 1'b0) begin n_err++; $display("FAIL rst_tready: high seen=%b, required 0", bad_r); end
    n_cmp++; if (out_cnt !== 0) begin n_err++; $display("FAIL rst_outcnt: got %0d, required 0", out_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (m_axis_tready !== 1'b0) begin n_err++; $display("FAIL rel_tready_pre: got %b, required 0", m_axis_tready); end
    @(posedge clk); #1;
    n_cmp++; if (m_axis_tready !== 1'b1) begin n_err++; $display("FAIL rel_tready_post: got %b, required 1", m_axis_tready); end
  endtask

  task automatic test_impulse;
    logic signed [15:0] y, ye;
    int lat, plen;
    for (int i = 0; i < 10; i++) begin
      send((i == 0) ? 16'sd16384 : 16'sd0, y, lat, plen);
      model_step((i == 0) ? 16384 : 0, ye);
      if (i == 0) begin
        n_cmp++; if (y !== 16'sd167) begin n_err++; $display("FAIL imp_y0: got %0d, required 167", y); end
      end
      if (i == 1) begin
        n_cmp++; if (y !== 16'sd22) begin n_err++; $display("FAIL imp_y1: got %0d, required 22", y); end
      end
      n_cmp++; if (y !== ye) begin n_err++; $display("FAIL imp_model[%0d]: got %0d, required %0d", i, y, ye); end
      n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL imp_latency[%0d]: got %0d, required 3", i, lat); end
      n_cmp++; if (plen !== 1) begin n_err++; $display("FAIL imp_pulse[%0d]: got %0d, required 1", i, plen); end
    end
  endtask

  task automatic test_reset_midop;
    logic signed [15:0] y;
    int lat, plen, c0;
    @(negedge clk);
    s_axis_tdata = 16'sd20000;
    s_axis_tvalid = 1'b1;
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    @(posedge clk); #1;
    c0 = out_cnt;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (m_axis_tdata !== 16'sd0) begin n_err++; $display("FAIL mid_tdata: got %0d, required 0", m_axis_tdata); end
    n_cmp++; if (m_axis_tready !== 1'b0) begin n_err++; $display("FAIL mid_tready: got %b, required 0", m_axis_tready); end
    repeat (5) @(posedge clk);
    #1;
    n_cmp++; if (out_cnt !== c0) begin n_err++; $display("FAIL mid_nopulse: got %0d pulses, required 0", out_cnt - c0); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
    send(16'sd16384, y, lat, plen);
    n_cmp++; if (y !== 16'sd167) begin n_err++; $display("FAIL mid_hist_clear: got %0d, required 167", y); end
    model_reset();
    apply_reset();
  endtask

  task automatic test_step;
    logic signed [15:0] y, ye;
    int lat, plen;
    for (int i = 0; i < 2000; i++) begin
      send(16'sd1000, y, lat, plen);
      model_step(1000, ye);
      if (i == 0) begin
        n_cmp++; if (y !== 16'sd10) begin n_err++; $display("FAIL step_y0: got %0d, required 10", y); end
      end
      n_cmp++; if (y !== ye) begin n_err++; $display("FAIL step_model[%0d]: got %0d, required %0d", i, y, ye); end
    end
  endtask

  task automatic test_busy_drop;
    logic signed [15:0] y, ye, obs;
    logic rdy;
    int lat, plen, c0, n;
    out_q.delete();
    c0 = out_cnt;
    @(negedge clk);
    n = 0;
    while (m_axis_tready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    s_axis_tdata = 16'sd5000;
    s_axis_tvalid = 1'b1;
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    @(negedge clk);
    rdy = m_axis_tready;
    s_axis_tdata = -16'sd7000;
    s_axis_tvalid = 1'b1;
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    model_step(5000, ye);
    obs = (out_q.size() > 0) ? out_q[0] : 'x;
    n_cmp++; if (rdy !== 1'b0) begin n_err++; $display("FAIL drop_tready: got %b, required 0", rdy); end
    n_cmp++; if (out_cnt - c0 !== 1) begin n_err++; $display("FAIL drop_count: got %0d outputs, required 1", out_cnt - c0); end
    n_cmp++; if (obs !== ye) begin n_err++; $display("FAIL drop_value: got %0d, required %0d", obs, ye); end
    send(16'sd0, y, lat, plen);
    model_step(0, ye);
    n_cmp++; if (y !== ye) begin n_err++; $display("FAIL drop_history: got %0d, required %0d", y, ye); end
  endtask

  task automatic test_back_to_back;
    logic signed [15:0] xv, ye, obs;
    logic signed [15:0] exp_q[$];
    int waits[$];
    int n;
    out_q.delete();
    for (int i = 0; i < 12; i++) begin
      xv = 16'(i * 2500 - 12000);
      @(negedge clk);
      n = 0;
      while (m_axis_tready !== 1'b1 && n < 10) begin @(negedge clk); n++; end
      waits.push_back(n);
      s_axis_tdata = xv;
      s_axis_tvalid = 1'b1;
      @(posedge clk);
      model_step(longint'(xv), ye);
      exp_q.push_back(ye);
    end
    #1 s_axis_tvalid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_cmp++; if (out_q.size() !== 12) begin n_err++; $display("FAIL b2b_count: got %0d, required 12", out_q.size()); end
    for (int i = 0; i < 12; i++) begin
      obs = (i < out_q.size()) ? out_q[i] : 'x;
      n_cmp++; if (obs !== exp_q[i]) begin n_err++; $display("FAIL b2b_value[%0d]: got %0d, required %0d", i, obs, exp_q[i]); end
      if (i > 0) begin
        n_cmp++; if (waits[i] !== 2) begin n_err++; $display("FAIL b2b_interval[%0d]: got %0d clocks, required 3", i, waits[i] + 1); end
      end
    end
  endtask

  task automatic test_sine;
    logic signed [15:0] xv, y, ye;
    int lat, plen;
    real xr;
    for (int i = 0; i < 1000; i++) begin
      xr = 8000.0 * $sin(6.283185307179586 * 0.005 * i) + real'($urandom_range(0, 600)) - 300.0;
      xv = 16'($rtoi(xr));
      send(xv, y, lat, plen);
      model_step(longint'(xv), ye);
      n_cmp++; if (y !== ye) begin n_err++; $display("FAIL sine_model[%0d]: got %0d, required %0d", i, y, ye); end
    end
  endtask

  task automatic test_saturation;
    logic signed [15:0] xs, ye;
    int n;
    for (int k = 0; k < 2; k++) begin
      xs = (k == 0) ? 16'sd30000 : -16'sd30000;
`ifdef IIR_DF1_SATURATE_EN
      ye = (k == 0) ? 16'sd32767 : -16'sd32768;
`else
      ye = (k == 0) ? -16'sd5538 : 16'sd5537;
`endif
      @(negedge clk);
      n = 0;
      while (m2_tready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      s2_tdata = xs;
      s2_tvalid = 1'b1;
      @(posedge clk); #1;
      s2_tvalid = 1'b0;
      n = 1;
      while (m2_tvalid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
      n_cmp++; if (m2_tdata !== ye) begin n_err++; $display("FAIL sat_value[%0d]: got %0d, required %0d", k, m2_tdata, ye); end
      n_cmp++; if (n !== 3) begin n_err++; $display("FAIL sat_latency[%0d]: got %0d, required 3", k, n); end
      repeat (2) @(posedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_reset_midop();
    test_step();
    test_busy_drop();
    test_back_to_back();
    test_sine();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
